// File: rtl/tilexy_miss_resp.sv
// Home-tile cache-miss responder: captures XA requests for this tile, runs one
// lookup at a time in FIFO order, and returns the line (or a NACK) on the X links.
//
// state    | meaning
// S_IDLE   | waiting for a queued request; latches the FIFO head when one exists
// S_LOOKUP | lk_en asserted, waiting for lk_rdy
// S_WAIT   | lookup outstanding, waiting for lk_vld
// S_SEND   | response packet driven on link r_link until that link is not busy
module tilexy_miss_resp #(
    parameter int tile_X = 0,
    parameter int tile_Y = 0,
    parameter int IDX    = 0,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0][164:0] XA_in,
    output logic [1:0]        XA_busy,
    output logic [1:0][731:0] X_out,
    input  logic [1:0]        X_out_busy,
    output logic              lk_en,
    output logic [36:0]       lk_addr,
    output logic [39:0]       lk_phy,
    input  logic              lk_rdy,
    input  logic              lk_vld,
    input  logic              lk_hit,
    input  logic              lk_shared,
    input  logic [527:0]      lk_data,
    output logic              drop_err
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int ENT_W = 37 + 40 + 4;
    localparam logic [1:0] OWN = (IDX < 2) ? 2'(tile_X) : 2'(tile_Y);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WAIT, S_SEND} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [ENT_W-1:0] r_mem [DEPTH];

    logic [36:0]      r_addr;
    logic [39:0]      r_phy;
    logic [3:0]       r_src;
    logic             r_link;
    logic [527:0]     r_data;
    logic             r_hit;
    logic             r_shared;

    logic [1:0]       w_req_vld;
    logic [ENT_W-1:0] w_entry [2];
    logic [ENT_W-1:0] w_head;
    logic [1:0]       w_dst;
    logic             w_pop;
    logic [CW-1:0]    w_free;
    logic             w_acc0;
    logic             w_acc1;
    logic             w_drop;
    logic [PW-1:0]    w_wr1;
    logic [731:0]     w_pkt;
    logic             w_unused;

    assign w_unused = ^XA_in;

    // Request decode; only the low two bits of TX/TY identify a tile.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_req_vld[i] = XA_in[i][163]
                         && (XA_in[i][77:76] == 2'(tile_X))
                         && (XA_in[i][82:81] == 2'(tile_Y));
            w_entry[i]   = {XA_in[i][36:0], XA_in[i][125:86], XA_in[i][129:126]};
        end
    end

    assign w_head = r_mem[r_rd_ptr];
    assign w_dst  = (IDX < 2) ? w_head[1:0] : w_head[3:2];
    assign w_pop  = (r_state == S_SEND) && !X_out_busy[r_link];

    // A same-cycle pop frees its slot for the incoming pushes; link 0 is taken first.
    assign w_free = CW'(DEPTH) - r_count + CW'(w_pop);
    assign w_acc0 = w_req_vld[0] && (w_free != '0);
    assign w_acc1 = w_req_vld[1] && (w_free > CW'(w_acc0));
    assign w_drop = (w_req_vld[0] && !w_acc0) || (w_req_vld[1] && !w_acc1);
    assign w_wr1  = r_wr_ptr + PW'(w_acc0);

    assign XA_busy = {2{r_count >= CW'(DEPTH - 2)}};

    always_ff @(posedge clk) begin
        if (w_acc0) r_mem[r_wr_ptr] <= w_entry[0];
        if (w_acc1) r_mem[w_wr1]    <= w_entry[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            drop_err <= 1'b0;
        end else begin
            r_count  <= r_count + CW'(w_acc0) + CW'(w_acc1) - CW'(w_pop);
            r_wr_ptr <= r_wr_ptr + PW'(w_acc0) + PW'(w_acc1);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            if (w_drop) drop_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_phy    <= '0;
            r_src    <= '0;
            r_link   <= 1'b0;
            r_data   <= '0;
            r_hit    <= 1'b0;
            r_shared <= 1'b0;
        end else begin
            if (r_state == S_IDLE && r_count != '0) begin
                r_addr <= w_head[80:44];
                r_phy  <= w_head[43:4];
                r_src  <= w_head[3:0];
                r_link <= (w_dst > OWN);
            end
            if (r_state == S_WAIT && lk_vld) begin
                r_data   <= lk_hit ? lk_data : '0;
                r_hit    <= lk_hit;
                r_shared <= lk_hit & lk_shared;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (r_count != '0)       w_next = S_LOOKUP;
            S_LOOKUP: if (lk_rdy)              w_next = S_WAIT;
            S_WAIT:   if (lk_vld)              w_next = S_SEND;
            S_SEND:   if (!X_out_busy[r_link]) w_next = S_IDLE;
            default:                           w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pkt           = '0;
        w_pkt[527:0]    = r_data;
        w_pkt[528]      = (IDX < 2);
        w_pkt[529]      = (IDX >= 2);
        w_pkt[534:530]  = {3'b000, r_src[1:0]};
        w_pkt[539:535]  = {3'b000, r_src[3:2]};
        w_pkt[579:540]  = r_phy;
        w_pkt[580]      = r_shared;
        w_pkt[728:581]  = {4{r_addr}};
        w_pkt[729]      = 1'b1;
        w_pkt[730]      = ~r_hit;
    end

    assign lk_addr = r_addr;
    assign lk_phy  = r_phy;

    always_comb begin
        lk_en = (r_state == S_LOOKUP);
        X_out = '0;
        if (r_state == S_SEND) X_out[r_link] = w_pkt;
    end

endmodule

// File: tb/tb_tilexy_miss_resp.sv
// Directed bench for tilexy_miss_resp at tile (1,2), ring stage 0, 8-entry FIFO.
module tb_tilexy_miss_resp;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0][164:0] XA_in;
    logic [1:0]        XA_busy;
    logic [1:0][731:0] X_out;
    logic [1:0]        X_out_busy;
    logic              lk_en;
    logic [36:0]       lk_addr;
    logic [39:0]       lk_phy;
    logic              lk_rdy, lk_vld, lk_hit, lk_shared;
    logic [527:0]      lk_data;
    logic              drop_err;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [39:0] PHY = 40'h12_3456_789A;
    logic [527:0] pat;
    logic [731:0] pkt;
    logic [731:0] p0;
    logic [164:0] rq;

    always #5 clk = ~clk;

    tilexy_miss_resp #(.tile_X(1), .tile_Y(2), .IDX(0), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .XA_in(XA_in), .XA_busy(XA_busy),
        .X_out(X_out), .X_out_busy(X_out_busy),
        .lk_en(lk_en), .lk_addr(lk_addr), .lk_phy(lk_phy),
        .lk_rdy(lk_rdy), .lk_vld(lk_vld), .lk_hit(lk_hit),
        .lk_shared(lk_shared), .lk_data(lk_data), .drop_err(drop_err)
    );

    task automatic check_val(input string tag, input logic [731:0] obs, input logic [731:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [164:0] mk_req(input logic [38:0] a, input logic [1:0] sx,
                                            input logic [1:0] sy, input logic [1:0] tx,
                                            input logic [1:0] ty);
        logic [164:0] r;
        r          = '0;
        r[38:0]    = a;
        r[80:76]   = {3'b000, tx};
        r[85:81]   = {3'b000, ty};
        r[125:86]  = PHY;
        r[129:126] = {sy, sx};
        r[163]     = 1'b1;
        return r;
    endfunction

    task automatic push(input int link, input logic [164:0] r);
        XA_in[link] = r;
        step();
        XA_in = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        XA_in = '0;
        X_out_busy = 2'b00;
        lk_rdy = 0; lk_vld = 0; lk_hit = 0; lk_shared = 0;
        lk_data = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_pkt(input int link, input string tag, output logic [731:0] p);
        bit found = 0;
        p = '0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (X_out[link][729]) begin
                found = 1;
                p = X_out[link];
            end else begin
                step();
            end
        end
        check_val({tag, " seen"}, 732'(found), 732'd1);
        if (found) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        pat = {33{16'hC0DE}};
        do_reset();

        // reset state
        check_val("rst X_out", X_out, '0);
        check_val("rst lk_en", 732'(lk_en), 0);
        check_val("rst XA_busy", 732'(XA_busy), 0);
        check_val("rst drop_err", 732'(drop_err), 0);
        check_val("rst count", 732'(dut.r_count), 0);

        // single hit, response forward on link 1
        lk_rdy = 1; lk_vld = 1; lk_hit = 1; lk_shared = 1; lk_data = pat;
        push(0, mk_req({2'b11, 37'h0ABCDE1}, 2'd3, 2'd0, 2'd1, 2'd2));
        check_val("hit count", 732'(dut.r_count), 1);
        check_val("hit X_out E", X_out, '0);
        step();
        check_val("hit lk_en", 732'(lk_en), 1);
        check_val("hit lk_addr", 732'(lk_addr), 732'(37'h0ABCDE1));
        check_val("hit lk_phy", 732'(lk_phy), 732'(PHY));
        step();
        check_val("hit lk_en wait", 732'(lk_en), 0);
        check_val("hit snd early", 732'(X_out[1][729]), 0);
        step();
        check_val("hit snd", 732'(X_out[1][729]), 1);
        check_val("hit TX", 732'(X_out[1][534:530]), 3);
        check_val("hit TY", 732'(X_out[1][539:535]), 0);
        check_val("hit expun", 732'(X_out[1][730]), 0);
        check_val("hit data", 732'(X_out[1][527:0]), 732'(pat));
        check_val("hit addr", 732'(X_out[1][728:581]), 732'({4{37'h0ABCDE1}}));
        check_val("hit sz", 732'(X_out[1][579:540]), 732'(PHY));
        check_val("hit shared", 732'(X_out[1][580]), 1);
        check_val("hit XDONE/YDONE", 732'(X_out[1][529:528]), 732'(2'b01));
        check_val("hit extra", 732'(X_out[1][731]), 0);
        check_val("hit link0 idle", X_out[0], '0);
        step();
        check_val("hit popped", 732'(dut.r_count), 0);
        check_val("hit X_out after", X_out, '0);

        // miss NACK, response back on link 0
        do_reset();
        lk_rdy = 1; lk_vld = 1; lk_hit = 0; lk_shared = 1; lk_data = pat;
        push(0, mk_req(39'h0000123, 2'd0, 2'd1, 2'd1, 2'd2));
        step(); step(); step();
        check_val("miss snd", 732'(X_out[0][729]), 1);
        check_val("miss expun", 732'(X_out[0][730]), 1);
        check_val("miss data", 732'(X_out[0][527:0]), 0);
        check_val("miss shared", 732'(X_out[0][580]), 0);
        check_val("miss TY", 732'(X_out[0][539:535]), 1);
        check_val("miss link1 idle", X_out[1], '0);
        step();

        // filtering and simultaneous arrival
        do_reset();
        push(0, mk_req(39'h1, 2'd3, 2'd0, 2'd2, 2'd2));
        rq = mk_req(39'h2, 2'd3, 2'd0, 2'd1, 2'd2);
        rq[163] = 1'b0;
        push(1, rq);
        check_val("filter count", 732'(dut.r_count), 0);
        XA_in[0] = mk_req(39'h0AAAA, 2'd3, 2'd0, 2'd1, 2'd2);
        XA_in[1] = mk_req(39'h0BBBB, 2'd3, 2'd0, 2'd1, 2'd2);
        step();
        XA_in = '0;
        check_val("simul count", 732'(dut.r_count), 2);
        lk_rdy = 1; lk_vld = 1; lk_hit = 1; lk_data = pat;
        wait_pkt(1, "simul first", pkt);
        check_val("simul first addr", 732'(pkt[728:581]), 732'({4{37'h0AAAA}}));
        wait_pkt(1, "simul second", pkt);
        check_val("simul second addr", 732'(pkt[728:581]), 732'({4{37'h0BBBB}}));

        // full, busy, drop, push-with-pop, wrap order
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            push(0, mk_req(39'(37'h1000 + k - 1), 2'd0, 2'd0, 2'd1, 2'd2));
            check_val($sformatf("full busy k=%0d", k), 732'(XA_busy), (k >= 6) ? 732'd3 : 732'd0);
        end
        check_val("full drop_err pre", 732'(drop_err), 0);
        push(0, mk_req(39'h1FFF, 2'd0, 2'd0, 2'd1, 2'd2));
        check_val("full drop_err", 732'(drop_err), 1);
        check_val("full count", 732'(dut.r_count), 8);
        lk_rdy = 1; lk_vld = 1; lk_hit = 1;
        step(); step();
        check_val("full send snd", 732'(X_out[0][729]), 1);
        check_val("full send addr", 732'(X_out[0][728:581]), 732'({4{37'h1000}}));
        lk_rdy = 0; lk_vld = 0;
        push(0, mk_req(39'h1AAA, 2'd0, 2'd0, 2'd1, 2'd2));
        check_val("pushpop count", 732'(dut.r_count), 8);
        check_val("drop_err sticky", 732'(drop_err), 1);
        lk_rdy = 1; lk_vld = 1;
        for (int k = 1; k <= 8; k++) begin
            wait_pkt(0, $sformatf("drain %0d", k), pkt);
            check_val($sformatf("drain addr %0d", k), 732'(pkt[728:581]),
                      (k < 8) ? 732'({4{37'(37'h1000 + k)}}) : 732'({4{37'h1AAA}}));
        end

        // backpressure on link 1
        do_reset();
        X_out_busy = 2'b10;
        lk_rdy = 1; lk_vld = 1; lk_hit = 1; lk_data = pat;
        push(0, mk_req(39'h0555, 2'd3, 2'd0, 2'd1, 2'd2));
        step(); step(); step();
        p0 = X_out[1];
        check_val("bp snd", 732'(p0[729]), 1);
        check_val("bp addr", 732'(p0[728:581]), 732'({4{37'h0555}}));
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("bp hold %0d", i), X_out[1], p0);
            check_val($sformatf("bp count %0d", i), 732'(dut.r_count), 1);
            if (i < 4) step();
        end
        X_out_busy = 2'b00;
        step();
        check_val("bp popped", 732'(dut.r_count), 0);
        check_val("bp X_out after", X_out, '0);

        // reset while a lookup is outstanding
        do_reset();
        lk_rdy = 1; lk_vld = 0; lk_hit = 1; lk_data = pat;
        push(0, mk_req(39'h0777, 2'd3, 2'd0, 2'd1, 2'd2));
        step();
        check_val("rw lk_en", 732'(lk_en), 1);
        step();
        check_val("rw lk_en wait", 732'(lk_en), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rw lk_en after", 732'(lk_en), 0);
        check_val("rw X_out after", X_out, '0);
        check_val("rw count after", 732'(dut.r_count), 0);
        lk_vld = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val($sformatf("rw no pkt %0d", i), X_out, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tilexy_miss_resp.md
# tileXY_miss_resp

Home-tile responder for cache-miss address requests travelling on the XA ring links. It is one per tile and ring stage, and sits beside tileXY_cl_fifo. It captures requests addressed to its own tile, serialises them through a local lookup handshake, and transmits the resulting cache line, or a NACK, back to the originating tile as a wrreq-format packet on the X data links.

## Interface
Parameters:
- tile_X, 0, this tile's X coordinate (2 bits used).
- tile_Y, 0, this tile's Y coordinate (2 bits used).
- IDX, 0, ring stage: IDX<2 routes on X, IDX>=2 routes on Y.
- DEPTH, 8, request FIFO entries (power of two).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- XA_in  in  [1:0][164:0]  request links; 0 from back neighbour, 1 from forward neighbour. Fields:
  - [38:0] request address.
  - [80:76] TX, [85:81] TY.
  - [125:86] phy.
  - [129:126] source tile {srcY,srcX}.
  - [163] snd.
- XA_busy  out  [1:0]  backpressure to both request senders.
- X_out  out  [1:0][731:0]  response links; 0 back, 1 forward. Fields:
  - [527:0] data.
  - [528] XDONE, [529] YDONE.
  - [534:530] TX, [539:535] TY.
  - [579:540] sz.
  - [580] shared.
  - [728:581] addr.
  - [729] snd.
  - [730] expun.
  - [731] extra, tied 0.
- X_out_busy  in  [1:0]  downstream response queue near-full, per link.
- lk_en  out  1  lookup request.
- lk_addr  out  37  lookup line address.
- lk_phy  out  40  lookup phy/size.
- lk_rdy  in  1  lookup accepted.
- lk_vld  in  1  lookup result valid.
- lk_hit  in  1  line present.
- lk_shared  in  1  line returned shared.
- lk_data  in  528  line data with ECC.
- drop_err  out  1  sticky: a request was lost because the FIFO was full.

## Operation
Request capture:
- Link i is accepted when snd=1 AND TX[1:0]==tile_X AND TY[1:0]==tile_Y.
- Each accepted request pushes {addr[36:0], phy, src} into the FIFO.
- When both links arrive in one cycle, link 0 is written first, then link 1. The count may rise by 2.
- A push with count==DEPTH is discarded and drop_err is set. drop_err clears only on rst.
- XA_busy[1:0] both equal (count >= DEPTH-2).

FSM states: IDLE, LOOKUP, WAIT, SEND.
- IDLE -> LOOKUP when the FIFO is non-empty. The head is latched into working registers.
- LOOKUP: lk_en=1 with lk_addr/lk_phy from the head. -> WAIT at the edge where lk_rdy=1.
- WAIT: lk_en=0. At the edge where lk_vld=1, capture lk_data, lk_hit and lk_shared, then -> SEND.
- SEND: drive the packet on the chosen link L. At the edge where X_out_busy[L]=0, pop the FIFO and go to IDLE.

Link selection:
- dst = srcX when IDX<2, srcY otherwise.
- own = tile_X when IDX<2, tile_Y otherwise.
- L=1 (forward) if dst>own, else L=0.
- A response to the own tile goes on link 0.

Response packet:
- data = hit ? lk_data : 0.
- XDONE = IDX<2; YDONE = IDX>=2.
- TX = {3'b0,srcX}; TY = {3'b0,srcY}.
- sz = phy.
- shared = hit & lk_shared.
- addr = four copies of addr[36:0].
- expun = ~hit (NACK).
- snd = 1.
- The non-selected link, and both links outside SEND, drive all zeros.

Ordering: responses leave strictly in FIFO order, with one lookup outstanding.

## Timing
Reset values:
- FSM = IDLE; count = 0; read and write pointers = 0.
- lk_en = 0; X_out = 0; drop_err = 0.
- XA_busy = 0 (derived from count).
- Reset mid-operation abandons any lookup or packet in flight. Responses in progress on lk_vld are ignored after reset.

Cycle timing:
- A request sampled at edge E is visible in the FIFO after E.
- IDLE -> LOOKUP at E+1, so lk_en is high in the cycle after E+1.
- If lk_rdy and lk_vld each take 0 wait cycles, X_out snd rises after E+3. Minimum latency is 3 cycles.
- The packet on X_out is held stable while X_out_busy[L]=1.
- Push and pop in the same cycle leave count unchanged, including when count==DEPTH: the pop frees space and the push is accepted, so there is no drop.
- Pointers wrap modulo DEPTH.
- lk_vld arriving in LOOKUP is ignored.

## Test plan
- Single hit: tile (1,2), IDX=0, request on link 0 with addr=0x0ABCDE1, src=(Y0,X3), lk_rdy and lk_vld immediate, lk_hit=1, lk_data=pattern.
  - Required: X_out[1] snd=1 three cycles after capture, TX=3, TY=0, expun=0, data=pattern, addr=4×0x0ABCDE1.
- Miss NACK: same setup with lk_hit=0, src X=0.
  - Required: packet on link 0, expun=1, data=0, shared=0.
- Simultaneous arrival: both links deliver at one edge.
  - Required: count=2; link-0 request is answered first, link-1 request second.
- Full and busy: 8 pushes with lk_rdy=0.
  - Required: XA_busy=11 once count>=6; a 9th push sets drop_err=1 and count stays 8; a push coinciding with a pop is not dropped.
- Backpressure: hold X_out_busy[1]=1 for 5 cycles during SEND.
  - Required: packet stable for 5 cycles, pop on the first cycle busy=0.
- Reset mid-WAIT: assert rst while in WAIT.
  - Required: next cycle lk_en=0, X_out=0, count=0; a later lk_vld produces no packet.
